// File: rtl/cmd_frame_reader.sv
// cmd_frame_reader: pops host bytes from the command FIFO, hunts for the sync
// byte, assembles 7-byte frames (sync, op, x_lo, x_hi, y_lo, y_hi, chk) and
// verifies an XOR checksum before presenting each command downstream.
//
// Ports:
//   clk, reset             - clock, synchronous active-high reset
//   fifo_empty/pop/data    - FIFO read side; data valid the cycle after a pop
//   cmd_valid/ready        - command handshake to the motion controller
//   cmd_op/x/y             - decoded command, stable while cmd_valid is high
//   err_pulse              - one-cycle pulse per checksum mismatch
//   err_cnt                - saturating checksum mismatch counter
//   busy                   - frame in progress or command pending
module cmd_frame_reader #(
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_empty,
    output logic                     fifo_pop,
    input  logic [7:0]               fifo_data,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [7:0]               cmd_op,
    output logic [15:0]              cmd_x,
    output logic [15:0]              cmd_y,
    output logic                     err_pulse,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic                     busy
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_CAPTURE,
        S_EMIT
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               idx_q, idx_d;
    logic [7:0]               acc_q, acc_d;
    logic [7:0]               op_q, op_d;
    logic [15:0]              x_q, x_d;
    logic [15:0]              y_q, y_d;
    logic [7:0]               cmd_op_q, cmd_op_d;
    logic [15:0]              cmd_x_q, cmd_x_d;
    logic [15:0]              cmd_y_q, cmd_y_d;
    logic                     err_pulse_q, err_pulse_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     pop_c;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        op_d        = op_q;
        x_d         = x_q;
        y_d         = y_q;
        cmd_op_d    = cmd_op_q;
        cmd_x_d     = cmd_x_q;
        cmd_y_d     = cmd_y_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        pop_c       = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                pop_c = !fifo_empty;
                if (!fifo_empty) begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                state_d = S_FETCH;
                if (idx_q == 3'd0) begin
                    // Hunting: anything other than sync is dropped.
                    if (fifo_data == SYNC_BYTE) begin
                        idx_d = 3'd1;
                        acc_d = 8'h00;
                    end
                end else if (idx_q == 3'd6) begin
                    if (fifo_data == acc_q) begin
                        cmd_op_d = op_q;
                        cmd_x_d  = x_q;
                        cmd_y_d  = y_q;
                        state_d  = S_EMIT;
                    end else begin
                        // Bad frame is dropped whole; hunting restarts
                        // with the next byte from the FIFO.
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                        end
                        idx_d = 3'd0;
                    end
                end else begin
                    acc_d = acc_q ^ fifo_data;
                    idx_d = idx_q + 3'd1;
                    case (idx_q)
                        3'd1:    op_d       = fifo_data;
                        3'd2:    x_d[7:0]   = fifo_data;
                        3'd3:    x_d[15:8]  = fifo_data;
                        3'd4:    y_d[7:0]   = fifo_data;
                        3'd5:    y_d[15:8]  = fifo_data;
                        default: ;
                    endcase
                end
            end

            S_EMIT: begin
                if (cmd_ready) begin
                    idx_d   = 3'd0;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            idx_q       <= 3'd0;
            acc_q       <= 8'h00;
            op_q        <= 8'h00;
            x_q         <= 16'h0000;
            y_q         <= 16'h0000;
            cmd_op_q    <= 8'h00;
            cmd_x_q     <= 16'h0000;
            cmd_y_q     <= 16'h0000;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cmd_op_q    <= cmd_op_d;
            cmd_x_q     <= cmd_x_d;
            cmd_y_q     <= cmd_y_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Pop is combinational; masking with reset keeps a byte from being
    // consumed on the same edge that reset discards the FSM state.
    assign fifo_pop  = pop_c && !reset;
    assign cmd_valid = (state_q == S_EMIT);
    assign cmd_op    = cmd_op_q;
    assign cmd_x     = cmd_x_q;
    assign cmd_y     = cmd_y_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != S_FETCH) || (idx_q != 3'd0);

endmodule

// File: tb/tb_cmd_frame_reader.sv
// Testbench for cmd_frame_reader: behavioural FIFO, vector table of frame
// streams, plus directed sequences for backpressure, slow feed, reset, saturation.
module tb_cmd_frame_reader;

    localparam logic [55:0] VF  = 56'hA5_01_34_12_78_56_09;
    localparam logic [55:0] BAD = 56'hA5_00_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty = 1'b1;
    logic        fifo_pop;
    logic [7:0]  fifo_data = 8'h00;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_x;
    logic [15:0] cmd_y;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        busy;

    always #5 clk = ~clk;

    cmd_frame_reader #(
        .SYNC_BYTE     (8'hA5),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .busy       (busy)
    );

    // Behavioural FIFO: pop seen during a cycle delivers data after the edge.
    logic [7:0] fq[$];
    logic       pop_s = 1'b0;

    always @(posedge clk) begin
        if (pop_s && fq.size() > 0) fifo_data <= fq.pop_front();
        #2;
        fifo_empty = (fq.size() == 0);
    end

    // Monitor
    int          cyc = 0;
    int          pop_cyc[$];
    int          rise_cyc[$];
    int          hs_cyc[$];
    logic [39:0] got[$];
    int          errp = 0;
    int          bad_empty = 0;
    int          bad_emit = 0;
    int          bad_reset = 0;
    int          unstable = 0;
    logic        pv = 1'b0;
    logic [39:0] pcmd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        pop_s = fifo_pop;
        if (fifo_pop) begin
            pop_cyc.push_back(cyc);
            if (fifo_empty) bad_empty++;
            if (cmd_valid) bad_emit++;
            if (reset) bad_reset++;
        end
        if (err_pulse) errp++;
        if (cmd_valid && !pv) rise_cyc.push_back(cyc);
        if (cmd_valid && pv && {cmd_op, cmd_x, cmd_y} != pcmd) unstable++;
        if (cmd_valid && cmd_ready) begin
            got.push_back({cmd_op, cmd_x, cmd_y});
            hs_cyc.push_back(cyc);
        end
        pv   = cmd_valid;
        pcmd = {cmd_op, cmd_x, cmd_y};
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [55:0] f);
        for (int j = 0; j < 7; j++) fq.push_back(f[55-8*j -: 8]);
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (fq.size() == 0 && !busy && !cmd_valid && !err_pulse) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: idle timeout after %0d cycles", name, max);
        end
        tick();
    endtask

    typedef struct {
        int           n;
        logic [127:0] b;
        int           cmds;
        logic [7:0]   op;
        logic [15:0]  x;
        logic [15:0]  y;
        int           errs;
        bit           lat;
    } vec_t;

    vec_t v[6];
    int   p0, g0, e0, r0, np;
    int   exp_ec;

    initial begin
        v[0] = '{7, {VF, 72'h0}, 1, 8'h01, 16'h1234, 16'h5678, 0, 1'b1};
        v[1] = '{10, {24'h00FF5A, VF, 48'h0}, 1, 8'h01, 16'h1234, 16'h5678,
                 0, 1'b0};
        v[2] = '{14, {56'hA5_01_34_12_78_56_08, VF, 16'h0}, 1, 8'h01,
                 16'h1234, 16'h5678, 1, 1'b0};
        v[3] = '{7, {56'hA5_10_00_80_FF_7F_10, 72'h0}, 1, 8'h10, 16'h8000,
                 16'h7FFF, 0, 1'b1};
        v[4] = '{7, {56'hA5_A5_01_00_02_00_A6, 72'h0}, 1, 8'hA5, 16'h0001,
                 16'h0002, 0, 1'b1};
        v[5] = '{14, {56'hA5_FF_FF_FF_FF_FF_00, 56'hA5_10_00_80_FF_7F_10,
                 16'h0}, 1, 8'h10, 16'h8000, 16'h7FFF, 1, 1'b0};
        exp_ec = 0;

        // Reset with a byte waiting: nothing may be popped.
        fq.push_back(8'h00);
        repeat (3) tick();
        @(negedge clk);
        check("rst_pop", fifo_pop, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_cmd", {cmd_op, cmd_x, cmd_y}, 0);
        check("rst_errp", err_pulse, 0);
        check("rst_fifo_kept", fq.size(), 1);
        tick();
        reset = 1'b0;
        wait_idle("rst_drain", 50);

        for (int i = 0; i < 6; i++) begin
            p0 = pop_cyc.size();
            g0 = got.size();
            e0 = errp;
            r0 = rise_cyc.size();
            for (int j = 0; j < v[i].n; j++) fq.push_back(v[i].b[127-8*j -: 8]);
            wait_idle($sformatf("v%0d_idle", i), 200);
            exp_ec += v[i].errs;
            check($sformatf("v%0d_pops", i), pop_cyc.size() - p0, v[i].n);
            check($sformatf("v%0d_cmds", i), got.size() - g0, v[i].cmds);
            if (got.size() > g0)
                check($sformatf("v%0d_cmd", i), got[$],
                      {v[i].op, v[i].x, v[i].y});
            check($sformatf("v%0d_errp", i), errp - e0, v[i].errs);
            check($sformatf("v%0d_errcnt", i), err_cnt, exp_ec);
            if (v[i].lat && pop_cyc.size() >= p0 + 7 && rise_cyc.size() > r0) begin
                check($sformatf("v%0d_lat", i), rise_cyc[r0] - pop_cyc[p0], 14);
                check($sformatf("v%0d_span", i),
                      pop_cyc[p0+6] - pop_cyc[p0], 12);
            end
        end

        // Backpressure: two frames queued, downstream stalled.
        cmd_ready = 1'b0;
        g0 = got.size();
        r0 = rise_cyc.size();
        p0 = pop_cyc.size();
        push_frame(VF);
        push_frame(56'hA5_10_00_80_FF_7F_10);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_valid) break;
        end
        check("bp_valid1", cmd_valid, 1);
        tick();
        np = pop_cyc.size();
        repeat (20) @(negedge clk);
        check("bp_no_pop", pop_cyc.size() - np, 0);
        check("bp_still_valid", cmd_valid, 1);
        check("bp_cmd1", {cmd_op, cmd_x, cmd_y}, {8'h01, 16'h1234, 16'h5678});
        if (rise_cyc.size() > r0)
            check("bp_lat1", rise_cyc[r0] - pop_cyc[p0], 14);
        @(posedge clk);
        #1 cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cmd_valid) break;
        end
        check("bp_valid2", cmd_valid, 1);
        tick();
        check("bp_hs1", got.size() - g0, 1);
        if (rise_cyc.size() > r0 + 1 && hs_cyc.size() > 0)
            check("bp_lat2", rise_cyc[r0+1] - hs_cyc[$], 15);
        cmd_ready = 1'b1;
        wait_idle("bp_idle", 100);
        check("bp_cmds", got.size() - g0, 2);
        if (got.size() >= g0 + 2)
            check("bp_cmd2", got[g0+1], {8'h10, 16'h8000, 16'h7FFF});

        // Slow feed: one byte every 5 cycles.
        g0 = got.size();
        p0 = pop_cyc.size();
        for (int j = 0; j < 7; j++) begin
            fq.push_back(VF[55-8*j -: 8]);
            repeat (5) tick();
        end
        wait_idle("slow_idle", 100);
        check("slow_pops", pop_cyc.size() - p0, 7);
        check("slow_cmds", got.size() - g0, 1);
        if (got.size() > g0)
            check("slow_cmd", got[$], {8'h01, 16'h1234, 16'h5678});

        // Reset in the middle of a frame.
        fq.push_back(8'hA5);
        fq.push_back(8'h01);
        fq.push_back(8'h34);
        repeat (10) tick();
        @(negedge clk);
        check("mid_busy", busy, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_cmd", {cmd_op, cmd_x, cmd_y}, 0);
        check("mid_rst_errcnt", err_cnt, 0);
        check("mid_rst_errp", err_pulse, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pop", fifo_pop, 0);
        exp_ec = 0;
        tick();
        g0 = got.size();
        push_frame(VF);
        wait_idle("mid_idle", 100);
        check("mid_cmds", got.size() - g0, 1);
        if (got.size() > g0)
            check("mid_cmd", got[$], {8'h01, 16'h1234, 16'h5678});

        // Saturation of the error counter.
        e0 = errp;
        g0 = got.size();
        for (int f = 0; f < 255; f++) push_frame(BAD);
        wait_idle("sat_idle", 5000);
        check("sat_errcnt255", err_cnt, 8'hFF);
        check("sat_errp255", errp - e0, 255);
        check("sat_nocmd", got.size() - g0, 0);
        e0 = errp;
        push_frame(BAD);
        wait_idle("sat_idle2", 100);
        check("sat_hold", err_cnt, 8'hFF);
        check("sat_errp_more", errp - e0, 1);

        check("pop_while_empty", bad_empty, 0);
        check("pop_while_emit", bad_emit, 0);
        check("pop_while_reset", bad_reset, 0);
        check("cmd_stable", unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_frame_reader.md
# cmd_frame_reader

Read-side consumer of the 8-bit command FIFO that buffers host bytes ahead of the plotter motion logic. It pops bytes one at a time and hunts for a sync byte. It assembles fixed 7-byte command frames and checks an XOR checksum. Each valid command is presented to the motion controller over a valid/ready handshake. When the downstream stalls, the block stops popping, so the FIFO absorbs the backpressure.

## Interface
Parameters:
- SYNC_BYTE, 8'hA5, frame start marker
- ERR_CNT_WIDTH, 8, width of saturating checksum-error counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_pop  out  1  pop request to FIFO
- fifo_data  in  8  FIFO read data; holds popped byte in the cycle after the pop cycle
- cmd_valid  out  1  command available
- cmd_ready  in  1  downstream accepts command
- cmd_op  out  8  opcode
- cmd_x  out  16  X coordinate
- cmd_y  out  16  Y coordinate
- err_pulse  out  1  one-cycle pulse on checksum mismatch
- err_cnt  out  ERR_CNT_WIDTH  checksum mismatch count, saturating
- busy  out  1  frame in progress or command pending

## Operation
- Frame format (byte index 0..6):
  - 0: SYNC_BYTE
  - 1: op
  - 2: x[7:0]
  - 3: x[15:8]
  - 4: y[7:0]
  - 5: y[15:8]
  - 6: chk, where chk = op^x_lo^x_hi^y_lo^y_hi
- FSM states: FETCH, CAPTURE, EMIT. A 3-bit byte index idx accompanies the FSM.
- FETCH:
  - fifo_pop = !fifo_empty, combinational.
  - If fifo_empty=0, go to CAPTURE; otherwise stay in FETCH.
- CAPTURE: sample fifo_data, then:
  - idx=0: if byte==SYNC_BYTE, set idx=1 and clear the XOR accumulator. Otherwise discard the byte and keep idx=0. Either way, go to FETCH.
  - idx=1..5: store the byte in its field register, XOR it into the accumulator, idx++, go to FETCH.
  - idx=6, byte==accumulator: load cmd_op/cmd_x/cmd_y from the field registers, go to EMIT.
  - idx=6, byte!=accumulator: err_pulse=1 for the next cycle, err_cnt+1 (saturating at all-ones), idx=0, go to FETCH. There is no rescan of the bad frame's bytes.
- EMIT:
  - cmd_valid=1; fifo_pop=0.
  - cmd_op/x/y are held stable.
  - On cmd_valid & cmd_ready: idx=0, go to FETCH.
- busy = (state!=FETCH) || (idx!=0).
- The field registers are separate from the cmd_* outputs. cmd_* change only on entry to EMIT.

## Timing
- fifo_pop is asserted only in FETCH, and only while fifo_empty=0. It is never asserted in CAPTURE or EMIT, or while reset=1.
- Peak throughput is one byte per 2 cycles. From the first pop of a frame with all 7 bytes queued, cmd_valid rises 14 cycles later, on the edge closing the 7th CAPTURE.
- Minimum handshake: cmd_valid high for 1 cycle if cmd_ready=1. The next pop can occur in the cycle after the handshake.
- While fifo_empty=1, the FSM waits in FETCH and partial-frame state is preserved. No timeout.
- Reset (synchronous, takes effect on the edge where reset=1):
  - state=FETCH, idx=0, accumulator=0.
  - cmd_valid=0, cmd_op/x/y=0, err_pulse=0, err_cnt=0, busy=0, fifo_pop=0.
  - Reset mid-frame or mid-EMIT drops the partial or pending command. Bytes already popped are lost.
- err_cnt holds at 2^ERR_CNT_WIDTH-1 once saturated. err_pulse still fires on each further mismatch.

## Test plan
- Reset, then push A5 01 34 12 78 56 09 → fifo_pop on 7 separate cycles, 2 apart; cmd_valid rises 14 cycles after the first pop with cmd_op=01, cmd_x=1234, cmd_y=5678; err_cnt=0.
- Push 00 FF 5A then the same valid frame → 3 bytes discarded at idx=0; one command with identical values; err_pulse never asserted.
- Push A5 01 34 12 78 56 08 then the valid frame → err_pulse for exactly 1 cycle, err_cnt=1, no cmd_valid for the bad frame; the following frame emits op=01, x=1234, y=5678.
- Queue two valid frames with cmd_ready=0 for 20 cycles after the first cmd_valid → no fifo_pop while in EMIT; cmd_* stable; after cmd_ready=1 for 1 cycle, the second frame is emitted 14 cycles later.
- Feed the frame one byte every 5 cycles (fifo_empty toggling) → fifo_pop never asserted while fifo_empty=1; correct command emitted.
- Assert reset for 1 cycle after 3 bytes of a frame, then send a full valid frame → all outputs zero after reset, busy=0; the new frame decodes correctly. Separately, send 256 bad frames → err_cnt saturates at FF.
